jk_bank_writer: RTL and testbench

JK_BANK_WRITER -- requirements
Module: jk_bank_writer

---
 rtl/jk_bank_writer_pkg.sv | 15 +
 rtl/jk_bank_writer_excite.sv | 22 ++
 rtl/jk_bank_writer.sv | 101 ++++++++++
 tb/tb_jk_bank_writer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/jk_bank_writer_pkg.sv
// Shared definitions for the JK bank writer: FSM state encoding and default sizing.
package jk_bank_writer_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/jk_bank_writer_excite.sv
// Per-bit JK excitation: turns a desired bit T and the present bank bit Q into J/K.
module jk_excite #(
  parameter int TOGGLE_MODE = 0
) (
  input  logic t_i,
  input  logic q_i,
  output logic j_o,
  output logic k_o
);

  // Toggle mode flips any differing bit; otherwise bits are explicitly set or cleared.
  always_comb begin
    if (TOGGLE_MODE != 0) begin
      j_o = t_i ^ q_i;
      k_o = t_i ^ q_i;
    end else begin
      j_o = t_i & ~q_i;
      k_o = ~t_i & q_i;
    end
  end

endmodule

// File: rtl/jk_bank_writer.sv
// Writes a target word into an external JK flip-flop bank, verifying the result
// by readback and retrying a bounded number of times before flagging an error.
module jk_bank_writer
  import jk_bank_writer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int MAX_RETRY   = DEFAULT_MAX_RETRY,
  parameter int TOGGLE_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             e_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [CW-1:0]    retry_q, retry_d;
  logic [CW-1:0]    retryInc;
  logic             busy_q, done_q, error_q;
  logic [WIDTH-1:0] jRaw, kRaw;
  logic             driveActive;

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    jk_excite #(
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_excite (
      .t_i(target_q[i]),
      .q_i(q_i[i]),
      .j_o(jRaw[i]),
      .k_o(kRaw[i])
    );
  end

  // The bank only sees excitation during the single DRIVE cycle.
  assign driveActive = (state_q == ST_DRIVE);
  assign e_o         = driveActive;
  assign j_o         = driveActive ? jRaw : '0;
  assign k_o         = driveActive ? kRaw : '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

  assign retryInc = (retry_q >= RETRY_MAX) ? retry_q : retry_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_i) begin
          target_d = target_i;
          retry_d  = '0;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: state_d = ST_CHECK;
      ST_CHECK: begin
        if (q_i == target_q) begin
          state_d = ST_DONE;
        end else begin
          retry_d = retryInc;
          state_d = (retryInc >= RETRY_MAX) ? ST_ERROR : ST_DRIVE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      retry_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      busy_q   <= (state_d == ST_DRIVE) || (state_d == ST_CHECK);
      done_q   <= (state_d == ST_DONE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_jk_bank_writer.sv
// Directed bench: two writers (set/clear and toggle excitation), each driving its own
// modelled JK bank; writer 0's bank can have bits forced stuck at zero.
module tb_jk_bank_writer;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [7:0] target;
  logic       loadEn;
  logic [7:0] loadVal0, loadVal1, stuckMask0;
  logic [7:0] bank0, bank1, j0, k0, j1, k1;
  logic       e0, e1, busy0, busy1, done0, done1, err0, err1;
  int         testCount = 0;
  int         failCount = 0;

  always #5 clk = ~clk;

  jk_bank_writer #(.WIDTH(8), .MAX_RETRY(3), .TOGGLE_MODE(0)) dut0 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .target_i(target), .q_i(bank0),
    .j_o(j0), .k_o(k0), .e_o(e0), .busy_o(busy0), .done_o(done0), .error_o(err0)
  );

  jk_bank_writer #(.WIDTH(8), .MAX_RETRY(3), .TOGGLE_MODE(1)) dut1 (
    .clk_i(clk), .rst_ni(rstN), .start_i(start), .target_i(target), .q_i(bank1),
    .j_o(j1), .k_o(k1), .e_o(e1), .busy_o(busy1), .done_o(done1), .error_o(err1)
  );

  function automatic logic [7:0] nextBank(input logic [7:0] q, input logic [7:0] j,
                                          input logic [7:0] k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case ({j[i], k[i]})
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = 1'b0;
        2'b11:   r[i] = ~q[i];
        default: r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  // Bank model: clocked JK flops, enabled by E, with optional stuck-at-0 bits on bank 0.
  always @(posedge clk) begin
    if (loadEn) begin
      bank0 <= loadVal0 & ~stuckMask0;
      bank1 <= loadVal1;
    end else begin
      if (e0) bank0 <= nextBank(bank0, j0, k0) & ~stuckMask0;
      if (e1) bank1 <= nextBank(bank1, j1, k1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] t);
    start  = s;
    target = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v0, input logic [7:0] v1);
    loadEn   = 1'b1;
    loadVal0 = v0;
    loadVal1 = v1;
    tick();
    loadEn = 1'b0;
  endtask

  initial begin
    rstN = 1'b0; loadEn = 1'b1; loadVal0 = 8'h00; loadVal1 = 8'h00; stuckMask0 = 8'h00;
    applyStimulus(1'b0, 8'h00);
    #2;
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_error", err0, 0);
    checkOutput("rst_e", e0, 0);
    checkOutput("rst_j", j0, 0);
    checkOutput("rst_k", k0, 0);
    repeat (2) tick();
    @(negedge clk);
    rstN = 1'b1; loadEn = 1'b0;
    tick();

    // Set/clear write of 0xA5 into an empty bank.
    applyStimulus(1'b1, 8'hA5); tick(); applyStimulus(1'b0, 8'h00);
    checkOutput("a5_e", e0, 1);
    checkOutput("a5_j", j0, 8'hA5);
    checkOutput("a5_k", k0, 8'h00);
    checkOutput("a5_busy", busy0, 1);
    tick();
    checkOutput("a5_chk_e", e0, 0);
    checkOutput("a5_chk_j", j0, 8'h00);
    checkOutput("a5_chk_done", done0, 0);
    checkOutput("a5_bank", bank0, 8'hA5);
    tick();
    checkOutput("a5_done", done0, 1);
    checkOutput("a5_done_busy", busy0, 0);
    tick();
    checkOutput("a5_done_pulse", done0, 0);

    // Toggle-mode write 0xF0 -> 0x0F; writer 0 sees the same vector in set/clear mode.
    preload(8'hF0, 8'hF0);
    applyStimulus(1'b1, 8'h0F); tick(); applyStimulus(1'b0, 8'h00);
    checkOutput("tg_e", e1, 1);
    checkOutput("tg_j", j1, 8'hFF);
    checkOutput("tg_k", k1, 8'hFF);
    checkOutput("sc_j", j0, 8'h0F);
    checkOutput("sc_k", k0, 8'hF0);
    tick();
    checkOutput("tg_bank", bank1, 8'h0F);
    checkOutput("tg_early_done", done1, 0);
    tick();
    checkOutput("tg_done", done1, 1);
    checkOutput("sc_done", done0, 1);
    tick();

    // Target already in the bank: still a DRIVE cycle, with no excitation.
    preload(8'h3C, 8'h3C);
    applyStimulus(1'b1, 8'h3C); tick(); applyStimulus(1'b0, 8'h00);
    checkOutput("eq_e", e0, 1);
    checkOutput("eq_j", j0, 8'h00);
    checkOutput("eq_k", k0, 8'h00);
    checkOutput("eq_j_tg", j1, 8'h00);
    tick(); tick();
    checkOutput("eq_done", done0, 1);
    checkOutput("eq_bank", bank0, 8'h3C);
    tick();

    // Bit 3 stuck low: three drive attempts, then a held error.
    stuckMask0 = 8'h08;
    preload(8'h00, 8'h00);
    applyStimulus(1'b1, 8'h08); tick(); applyStimulus(1'b0, 8'h00);
    checkOutput("st_e1", e0, 1);
    checkOutput("st_j1", j0, 8'h08);
    tick();
    checkOutput("st_c1_e", e0, 0);
    checkOutput("st_c1_bank", bank0, 8'h00);
    tick();
    checkOutput("st_e2", e0, 1);
    checkOutput("st_e2_done", done0, 0);
    tick();
    checkOutput("st_c2_e", e0, 0);
    tick();
    checkOutput("st_e3", e0, 1);
    tick();
    checkOutput("st_c3_err", err0, 0);
    checkOutput("st_c3_busy", busy0, 1);
    tick();
    checkOutput("st_err", err0, 1);
    checkOutput("st_err_busy", busy0, 0);
    checkOutput("st_err_done", done0, 0);
    checkOutput("st_err_e", e0, 0);
    tick();
    checkOutput("st_err_held", err0, 1);
    checkOutput("st_no_done", done0, 0);
    applyStimulus(1'b1, 8'h00); tick(); applyStimulus(1'b0, 8'h00);
    checkOutput("st_clr_err", err0, 0);
    checkOutput("st_clr_busy", busy0, 1);
    checkOutput("st_clr_e", e0, 1);
    tick(); tick();
    checkOutput("st_clr_done", done0, 1);
    tick();
    stuckMask0 = 8'h00;

    // A second start while busy must not disturb the latched target.
    preload(8'h00, 8'h00);
    applyStimulus(1'b1, 8'h5A); tick(); applyStimulus(1'b1, 8'hFF);
    checkOutput("ig_e", e0, 1);
    checkOutput("ig_j", j0, 8'h5A);
    tick();
    checkOutput("ig_busy", busy0, 1);
    applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("ig_done", done0, 1);
    checkOutput("ig_bank", bank0, 8'h5A);
    tick();
    checkOutput("ig_idle_busy", busy0, 0);
    checkOutput("ig_idle_e", e0, 0);
    tick();
    checkOutput("ig_bank_final", bank0, 8'h5A);

    // Reset during CHECK abandons the write with no later pulse.
    preload(8'h00, 8'h00);
    applyStimulus(1'b1, 8'h77); tick(); applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("rc_busy_before", busy0, 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rc_busy", busy0, 0);
    checkOutput("rc_e", e0, 0);
    checkOutput("rc_j", j0, 8'h00);
    checkOutput("rc_done", done0, 0);
    checkOutput("rc_error", err0, 0);
    @(negedge clk);
    rstN = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      checkOutput("rc_post_done", done0, 0);
      checkOutput("rc_post_error", err0, 0);
      checkOutput("rc_post_busy", busy0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
